// File: rtl/dma_wr.sv
// Write-direction DMA: buffers a 32-bit stream and writes it to SDRAM as Wishbone single-word cycles.
// Define DMA_WR_IRQ_EN to add the irq_o done-pulse output.
module dma_wr #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu2d_stb_i,
    input  logic        cpu2d_cyc_i,
    input  logic        cpu2d_we_i,
    input  logic [3:0]  cpu2d_sel_i,
    input  logic [31:0] cpu2d_dat_i,
    input  logic [31:0] cpu2d_adr_i,
    output logic        d2cpu_ack_o,
    output logic [31:0] d2cpu_dat_o,
    input  logic        s_tvalid,
    input  logic [31:0] s_tdata,
    output logic        s_tready,
    output logic        d2srm_stb_o,
    output logic        d2srm_cyc_o,
    output logic        d2srm_we_o,
    output logic [3:0]  d2srm_sel_o,
    output logic [31:0] d2srm_adr_o,
    output logic [31:0] d2srm_dat_o,
    input  logic        srm2d_ack_i,
`ifdef DMA_WR_IRQ_EN
    output logic        busy_o,
    output logic        irq_o
`else
    output logic        busy_o
`endif
);

    localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] CntFull = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] CntTwo  = (AW + 1)'(2);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StWrite
    } state_e;

    state_e        state_q;
    logic [31:0]   dst_q;
    logic [31:0]   len_q;
    logic          done_q;
    logic          ack_q;
    logic [31:0]   rdata_q;
    logic [29:0]   in_cnt_q;
    logic [29:0]   out_cnt_q;
    logic [31:0]   fifo_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
`ifdef DMA_WR_IRQ_EN
    logic          irq_q;
`endif

    logic [29:0] words;
    logic        busy;
    logic        in_write;
    logic        cpu_acc;
    logic        cpu_wr;
    logic        start;
    logic        push;
    logic        pop;
    logic        last;
    logic        done_evt;
    logic [31:0] rdata;
    logic        unused_inputs;

    assign words    = len_q[31:2];
    assign busy     = (state_q != StIdle);
    assign in_write = (state_q == StWrite);

    // Config registers only change while idle; accesses during a transfer are acked and dropped.
    assign cpu_acc = cpu2d_stb_i & cpu2d_cyc_i & ~ack_q;
    assign cpu_wr  = cpu_acc & cpu2d_we_i & ~busy;
    assign start   = cpu_wr & (cpu2d_adr_i[3:2] == 2'd2) & cpu2d_dat_i[0];

    assign s_tready = busy & (count_q != CntFull) & (in_cnt_q < words);
    assign push     = s_tvalid & s_tready;
    assign pop      = in_write & srm2d_ack_i;
    assign last     = ((out_cnt_q + 30'd1) == words);
    assign done_evt = (start & (words == '0)) | (pop & last);

    assign unused_inputs = ^{cpu2d_sel_i, cpu2d_adr_i[31:4], cpu2d_adr_i[1:0], len_q[1:0]};

    always_comb begin
        rdata = '0;
        case (cpu2d_adr_i[3:2])
            2'd0:    rdata = dst_q;
            2'd1:    rdata = len_q;
            2'd3:    rdata = {30'd0, done_q, busy};
            default: rdata = '0;
        endcase
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= s_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            dst_q     <= '0;
            len_q     <= '0;
            done_q    <= 1'b0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
`ifdef DMA_WR_IRQ_EN
            irq_q     <= 1'b0;
`endif
        end else begin
            ack_q <= cpu_acc;
            if (cpu_acc && !cpu2d_we_i) begin
                rdata_q <= rdata;
            end
            if (cpu_wr && (cpu2d_adr_i[3:2] == 2'd0)) begin
                dst_q <= cpu2d_dat_i;
            end
            if (cpu_wr && (cpu2d_adr_i[3:2] == 2'd1)) begin
                len_q <= cpu2d_dat_i;
            end

            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
                in_cnt_q <= in_cnt_q + 30'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (AW + 1)'(1);
            end else if (!push && pop) begin
                count_q <= count_q - (AW + 1)'(1);
            end

            if (done_evt) begin
                done_q <= 1'b1;
            end
`ifdef DMA_WR_IRQ_EN
            irq_q <= done_evt;
`endif

            unique case (state_q)
                StIdle: begin
                    if (start && (words != '0)) begin
                        done_q    <= 1'b0;
                        in_cnt_q  <= '0;
                        out_cnt_q <= '0;
                        state_q   <= StWait;
                    end
                end
                StWait: begin
                    if (count_q != '0) begin
                        state_q <= StWrite;
                    end
                end
                StWrite: begin
                    if (srm2d_ack_i) begin
                        out_cnt_q <= out_cnt_q + 30'd1;
                        if (last) begin
                            state_q <= StIdle;
                        end else if (count_q < CntTwo) begin
                            state_q <= StWait;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign d2cpu_ack_o = ack_q;
    assign d2cpu_dat_o = rdata_q;

    // Address and data only change on pop, so they stay stable for the whole cycle.
    assign d2srm_stb_o = in_write;
    assign d2srm_cyc_o = in_write;
    assign d2srm_we_o  = in_write;
    assign d2srm_sel_o = in_write ? 4'hF : 4'h0;
    assign d2srm_adr_o = in_write ? (dst_q + {out_cnt_q, 2'b00}) : '0;
    assign d2srm_dat_o = in_write ? fifo_q[rd_ptr_q] : '0;

    assign busy_o = busy;
`ifdef DMA_WR_IRQ_EN
    assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_dma_wr.sv
// Self-checking bench for dma_wr: register table, directed corner cases and randomized transfers
// checked against a transfer-level model (expected write list, word counts, done/busy/irq).
module tb_dma_wr;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu2d_stb_i, cpu2d_cyc_i, cpu2d_we_i;
    logic [3:0]  cpu2d_sel_i;
    logic [31:0] cpu2d_dat_i, cpu2d_adr_i;
    logic        d2cpu_ack_o;
    logic [31:0] d2cpu_dat_o;
    logic        s_tvalid;
    logic [31:0] s_tdata;
    logic        s_tready;
    logic        d2srm_stb_o, d2srm_cyc_o, d2srm_we_o;
    logic [3:0]  d2srm_sel_o;
    logic [31:0] d2srm_adr_o, d2srm_dat_o;
    logic        srm2d_ack_i;
    logic        busy_o;
`ifdef DMA_WR_IRQ_EN
    logic        irq_o;
`endif

    always #5 clk = ~clk;

    dma_wr #(.FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu2d_stb_i (cpu2d_stb_i),
        .cpu2d_cyc_i (cpu2d_cyc_i),
        .cpu2d_we_i  (cpu2d_we_i),
        .cpu2d_sel_i (cpu2d_sel_i),
        .cpu2d_dat_i (cpu2d_dat_i),
        .cpu2d_adr_i (cpu2d_adr_i),
        .d2cpu_ack_o (d2cpu_ack_o),
        .d2cpu_dat_o (d2cpu_dat_o),
        .s_tvalid    (s_tvalid),
        .s_tdata     (s_tdata),
        .s_tready    (s_tready),
        .d2srm_stb_o (d2srm_stb_o),
        .d2srm_cyc_o (d2srm_cyc_o),
        .d2srm_we_o  (d2srm_we_o),
        .d2srm_sel_o (d2srm_sel_o),
        .d2srm_adr_o (d2srm_adr_o),
        .d2srm_dat_o (d2srm_dat_o),
        .srm2d_ack_i (srm2d_ack_i),
`ifdef DMA_WR_IRQ_EN
        .busy_o      (busy_o),
        .irq_o       (irq_o)
`else
        .busy_o      (busy_o)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Transfer-level model
    logic [31:0] m_dst, m_len;
    logic        m_busy, m_done, m_irq;
    logic        s_busy, s_done;
    int          m_words, acc, wr;
    logic [31:0] exp_adr[$];
    logic [31:0] exp_dat[$];
    logic [31:0] offer_q[$];
    int          offer_idx;
    int          sd_dly, sd_wait;
    logic        held, expect_stb, gaps, seen_full;
    logic [31:0] held_adr, held_dat;

    typedef struct {
        logic        we;
        logic [1:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        int  cnt0;
        logic exp_rdy;
        @(posedge clk);
        #1;
        chk("busy", 32'(busy_o), 32'(m_busy));
        exp_rdy = m_busy && ((acc - wr) < DEPTH) && (acc < m_words);
        chk("tready", 32'(s_tready), 32'(exp_rdy));
`ifdef DMA_WR_IRQ_EN
        chk("irq", 32'(irq_o), 32'(m_irq));
`endif
        if (expect_stb) chk("stb_timing", 32'(d2srm_stb_o), 32'd1);
        expect_stb = 1'b0;
        m_irq  = 1'b0;
        s_busy = m_busy;
        s_done = m_done;
        cnt0   = acc - wr;
        if (cnt0 == DEPTH) seen_full = 1'b1;

        srm2d_ack_i = 1'b0;
        if (d2srm_stb_o) begin
            if (wr >= exp_adr.size()) begin
                chk("unexpected_stb", 32'(d2srm_stb_o), 32'd0);
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("hold_adr", d2srm_adr_o, held_adr);
                    chk("hold_dat", d2srm_dat_o, held_dat);
                end
                if (sd_wait >= sd_dly) begin
                    chk("wr_adr", d2srm_adr_o, exp_adr[wr]);
                    chk("wr_dat", d2srm_dat_o, exp_dat[wr]);
                    chk("wr_sel", 32'(d2srm_sel_o), 32'hF);
                    chk("wr_cyc_we", 32'({d2srm_cyc_o, d2srm_we_o}), 32'd3);
                    srm2d_ack_i = 1'b1;
                    wr++;
                    sd_wait = 0;
                    held = 1'b0;
                    if (wr == m_words) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                        m_irq  = 1'b1;
                    end else if (cnt0 >= 2) begin
                        expect_stb = 1'b1;
                    end
                end else begin
                    held = 1'b1;
                    held_adr = d2srm_adr_o;
                    held_dat = d2srm_dat_o;
                    sd_wait++;
                end
            end
        end else begin
            if (held) chk("stb_dropped", 32'(d2srm_stb_o), 32'd1);
            chk("idle_bus", 32'(|{d2srm_cyc_o, d2srm_we_o, d2srm_sel_o, d2srm_adr_o, d2srm_dat_o}),
                32'd0);
            if (s_busy && cnt0 > 0) expect_stb = 1'b1;
            sd_wait = 0;
            held = 1'b0;
        end

        if (offer_idx < offer_q.size() && (!gaps || $urandom_range(3) != 0)) begin
            s_tvalid = 1'b1;
            s_tdata  = offer_q[offer_idx];
            if (s_tready) begin
                acc++;
                offer_idx++;
            end
        end else begin
            s_tvalid = 1'b0;
            s_tdata  = $urandom;
        end
    endtask

    task automatic start_model();
        int n;
        m_words = int'(m_len[31:2]);
        if (m_words == 0) begin
            m_done = 1'b1;
            m_irq  = 1'b1;
        end else begin
            m_done = 1'b0;
            m_busy = 1'b1;
            acc = 0;
            wr  = 0;
            exp_adr.delete();
            exp_dat.delete();
            n = (offer_q.size() - offer_idx < m_words) ? offer_q.size() - offer_idx : m_words;
            for (int i = 0; i < n; i++) begin
                exp_adr.push_back(m_dst + 32'(4 * i));
                exp_dat.push_back(offer_q[offer_idx + i]);
            end
        end
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
        cpu2d_stb_i = 1'b1;
        cpu2d_cyc_i = 1'b1;
        cpu2d_we_i  = 1'b1;
        cpu2d_adr_i = {28'd0, a, 2'b00};
        cpu2d_dat_i = d;
        cpu2d_sel_i = 4'($urandom);
        if (!s_busy) begin
            case (a)
                2'd0: m_dst = d;
                2'd1: m_len = d;
                2'd2: if (d[0]) start_model();
                default: ;
            endcase
        end
        cycle();
        chk("cpu_ack", 32'(d2cpu_ack_o), 32'd1);
        cpu2d_stb_i = 1'b0;
        cpu2d_cyc_i = 1'b0;
        cycle();
        chk("cpu_ack_drop", 32'(d2cpu_ack_o), 32'd0);
    endtask

    task automatic wb_read(input logic [1:0] a, input logic [31:0] exp, input string name);
        cpu2d_stb_i = 1'b1;
        cpu2d_cyc_i = 1'b1;
        cpu2d_we_i  = 1'b0;
        cpu2d_adr_i = {28'd0, a, 2'b00};
        cpu2d_dat_i = $urandom;
        cycle();
        chk("cpu_rd_ack", 32'(d2cpu_ack_o), 32'd1);
        chk(name, d2cpu_dat_o, exp);
        cpu2d_stb_i = 1'b0;
        cpu2d_cyc_i = 1'b0;
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cpu2d_stb_i = 1'b0;
        cpu2d_cyc_i = 1'b0;
        srm2d_ack_i = 1'b0;
        s_tvalid = 1'b0;
        offer_q.delete();
        offer_idx = 0;
        exp_adr.delete();
        exp_dat.delete();
        m_dst = '0; m_len = '0; m_busy = 1'b0; m_done = 1'b0; m_irq = 1'b0;
        s_busy = 1'b0; s_done = 1'b0;
        m_words = 0; acc = 0; wr = 0;
        held = 1'b0; expect_stb = 1'b0; sd_wait = 0;
        cycle();
        chk("stb_after_reset", 32'({d2srm_stb_o, d2srm_cyc_o}), 32'd0);
        cycle();
        rst = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((m_busy || busy_o) && n < budget) begin
            cycle();
            n++;
        end
        chk("timeout", 32'(m_busy || busy_o), 32'd0);
        if (m_busy || busy_o) do_reset();
    endtask

    task automatic set_random_offers(input int n);
        offer_q.delete();
        for (int i = 0; i < n; i++) offer_q.push_back($urandom);
        offer_idx = 0;
    endtask

    task automatic run_xfer(input logic [31:0] dst, input logic [31:0] len, input int dly);
        sd_dly = dly;
        wb_write(2'd0, dst);
        wb_write(2'd1, len);
        wb_write(2'd2, 32'd1);
    endtask

    initial begin
        vecs[0] = '{1'b0, 2'd0, 32'h0, 32'h0};
        vecs[1] = '{1'b0, 2'd1, 32'h0, 32'h0};
        vecs[2] = '{1'b0, 2'd3, 32'h0, 32'h0};
        vecs[3] = '{1'b1, 2'd0, 32'h1234_5678, 32'h0};
        vecs[4] = '{1'b1, 2'd1, 32'hABCD_EF03, 32'h0};
        vecs[5] = '{1'b0, 2'd0, 32'h0, 32'h1234_5678};
        vecs[6] = '{1'b0, 2'd1, 32'h0, 32'hABCD_EF03};
        vecs[7] = '{1'b0, 2'd2, 32'h0, 32'h0};
        vecs[8] = '{1'b1, 2'd2, 32'hFFFF_FFFE, 32'h0};
        vecs[9] = '{1'b0, 2'd3, 32'h0, 32'h0};

        cpu2d_sel_i = 4'h0;
        cpu2d_dat_i = '0;
        cpu2d_adr_i = '0;
        cpu2d_we_i  = 1'b0;
        s_tdata     = '0;
        sd_dly      = 0;
        gaps        = 1'b0;
        seen_full   = 1'b0;
        do_reset();
        cycle();
        chk("rst_ack", 32'(d2cpu_ack_o), 32'd0);
        chk("rst_dat", d2cpu_dat_o, 32'd0);
        chk("rst_stb", 32'(d2srm_stb_o), 32'd0);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].we) wb_write(vecs[i].a, vecs[i].d);
            else wb_read(vecs[i].a, vecs[i].exp, "tbl_read");
        end

        // Basic four-word transfer
        offer_q = '{32'h11, 32'h22, 32'h33, 32'h44};
        offer_idx = 0;
        run_xfer(32'h3800_0000, 32'd16, 1);
        wait_done(200);
        chk("basic_writes", 32'(wr), 32'd4);
        wb_read(2'd3, 32'h2, "basic_status");

        // Zero-length start
        wb_write(2'd1, 32'd0);
        wb_write(2'd2, 32'd1);
        for (int i = 0; i < 4; i++) cycle();
        wb_read(2'd3, 32'h2, "zero_status");

        // FIFO fills behind a slow SDRAM
        set_random_offers(6);
        seen_full = 1'b0;
        run_xfer(32'h0000_1000, 32'd24, 6);
        wait_done(500);
        chk("full_writes", 32'(wr), 32'd6);
        chk("fifo_filled", 32'(seen_full), 32'd1);

        // More words offered than LEN allows
        set_random_offers(5);
        run_xfer(32'h0000_2000, 32'd8, 0);
        wait_done(200);
        for (int i = 0; i < 5; i++) cycle();
        chk("len_accepted", 32'(acc), 32'd2);
        chk("len_writes", 32'(wr), 32'd2);

        // Reset in the middle of a transfer
        begin
            int n = 0;
            set_random_offers(4);
            run_xfer(32'h1000_0000, 32'd16, 2);
            while (wr < 2 && n < 300) begin
                cycle();
                n++;
            end
            chk("mid_progress", 32'(wr >= 2), 32'd1);
            cycle();
            do_reset();
            wb_read(2'd3, 32'h0, "rst_status");
            wb_read(2'd0, 32'h0, "rst_dst");
            set_random_offers(3);
            run_xfer(32'h2000_0000, 32'd12, 0);
            wait_done(200);
            chk("after_rst_writes", 32'(wr), 32'd3);
            wb_read(2'd3, 32'h2, "after_rst_status");
        end

        // Config writes during a transfer are ignored
        set_random_offers(3);
        run_xfer(32'h3000_0000, 32'd12, 3);
        wb_write(2'd0, 32'hDEAD_0000);
        wb_write(2'd2, 32'd1);
        wb_write(2'd1, 32'd64);
        wait_done(300);
        chk("busy_writes", 32'(wr), 32'd3);
        wb_read(2'd0, 32'h3000_0000, "busy_dst");
        wb_read(2'd1, 32'd12, "busy_len");

        // Randomized transfers, including an address wrap
        gaps = 1'b1;
        for (int t = 0; t < 20; t++) begin
            int w;
            logic [31:0] dst;
            w   = int'($urandom_range(8, 1));
            dst = (t == 0) ? 32'hFFFF_FFF8 : $urandom;
            set_random_offers(w + int'($urandom_range(3)));
            run_xfer(dst, 32'(4 * w) | 32'($urandom_range(3)), int'($urandom_range(4)));
            wait_done(1000);
            chk("rand_writes", 32'(wr), 32'(w));
            wb_read(2'd3, {30'd0, s_done, s_busy}, "rand_status");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
